// File: rtl/ysyx_24070017_ifu_if.sv
// Bundle of every handshake and bus signal the fetch unit exchanges with
// instruction memory, the decode stage and the execute redirect path.
// The master side is the fetch unit; the slave side is its environment.
interface ysyx_24070017_ifu_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    // instruction memory request / response
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              imem_rsp_err;

    // handoff to decode
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;

    // redirect from execute
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    // access fault report
    logic              fault;
    logic [ADDR_W-1:0] fault_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output fault, fault_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  fault, fault_pc
    );
endinterface

// File: rtl/ysyx_24070017_ifu.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time, hands the
// fetched word to decode and follows redirects from execute. A redirect that
// races an in-flight request marks it stale (kill) so its response is dropped.
module ysyx_24070017_ifu #(
    parameter int              ADDR_W   = 32,
    parameter int              INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h80000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ysyx_24070017_ifu_if.master       bus
);
    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              kill;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              fault_q;
    logic [ADDR_W-1:0] fault_pc_q;

    logic req_fire;
    logic inst_fire;

    // Handshake outputs come from state alone, never from the ready inputs.
    assign bus.imem_req_valid = rst_n && (state == S_REQ);
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = (state == S_HOLD);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.fault          = fault_q;
    assign bus.fault_pc       = fault_pc_q;

    assign req_fire  = (state == S_REQ) && bus.imem_req_ready;
    assign inst_fire = (state == S_HOLD) && bus.inst_ready;

    // Fetch sequencer; a redirect always wins over the normal update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (bus.redirect_valid) begin
                        pc <= bus.redirect_pc;
                        if (req_fire) begin
                            kill  <= 1'b1;
                            state <= S_WAIT;
                        end
                    end else if (req_fire) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.redirect_valid) begin
                        pc <= bus.redirect_pc;
                        if (bus.imem_rsp_valid) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            kill <= 1'b1;
                        end
                    end else if (bus.imem_rsp_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else if (bus.imem_rsp_err) begin
                            fault_q    <= 1'b1;
                            fault_pc_q <= pc;
                            state      <= S_FAULT;
                        end else begin
                            inst_q    <= bus.imem_rsp_data;
                            inst_pc_q <= pc;
                            state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.redirect_valid) begin
                        pc    <= bus.redirect_pc;
                        state <= S_REQ;
                    end else if (inst_fire) begin
                        pc    <= pc + ADDR_W'(4);
                        state <= S_REQ;
                    end
                end
                default: begin
                    if (bus.redirect_valid) begin
                        pc      <= bus.redirect_pc;
                        fault_q <= 1'b0;
                        state   <= S_REQ;
                    end
                end
            endcase
        end
    end

    // Memory must only answer while a request is outstanding.
    rsp_only_in_wait: assert property (
        @(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> (state == S_WAIT)
    );

endmodule

// File: tb/tb_ysyx_24070017_ifu.sv
// Directed bench for the fetch unit: drives memory, decode and redirect
// by hand and compares outputs against hand-computed values.
module tb_ysyx_24070017_ifu;
    logic clk;
    logic rst_n;
    int   assertCount = 0;
    int   failCount   = 0;

    ysyx_24070017_ifu_if #(.ADDR_W(32), .INST_W(32)) bus ();

    ysyx_24070017_ifu #(
        .ADDR_W(32), .INST_W(32), .RESET_PC(32'h80000000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // set inputs for the coming edge, then step to 1 unit past that edge
    task automatic applyStimulus(
        input logic        req_ready  = 1'b1,
        input logic        rsp_valid  = 1'b0,
        input logic [31:0] rsp_data   = 32'h0,
        input logic        rsp_err    = 1'b0,
        input logic        inst_ready = 1'b1,
        input logic        redir      = 1'b0,
        input logic [31:0] redir_pc   = 32'h0
    );
        bus.imem_req_ready = req_ready;
        bus.imem_rsp_valid = rsp_valid;
        bus.imem_rsp_data  = rsp_data;
        bus.imem_rsp_err   = rsp_err;
        bus.inst_ready     = inst_ready;
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir_pc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // reset values
        @(posedge clk); @(posedge clk); #1;
        checkOutput("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        checkOutput("rst_fault", 32'(bus.fault), 32'd0);
        checkOutput("rst_inst", bus.inst, 32'h0);
        checkOutput("rst_inst_pc", bus.inst_pc, 32'h0);
        checkOutput("rst_fault_pc", bus.fault_pc, 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("first_req_addr", bus.imem_req_addr, 32'h80000000);

        // basic fetch, response one cycle after fire
        applyStimulus();
        checkOutput("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h00000413);
        checkOutput("hold_inst_valid", 32'(bus.inst_valid), 32'd1);
        checkOutput("hold_inst", bus.inst, 32'h00000413);
        checkOutput("hold_inst_pc", bus.inst_pc, 32'h80000000);
        applyStimulus();
        checkOutput("next_req_addr", bus.imem_req_addr, 32'h80000004);
        checkOutput("next_req_valid", 32'(bus.imem_req_valid), 32'd1);

        // decode stalls five cycles in HOLD
        applyStimulus();
        applyStimulus(1'b1, 1'b1, 32'h00100093);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            checkOutput("stall_inst_valid", 32'(bus.inst_valid), 32'd1);
            checkOutput("stall_inst", bus.inst, 32'h00100093);
            checkOutput("stall_inst_pc", bus.inst_pc, 32'h80000004);
            checkOutput("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        end
        applyStimulus();
        checkOutput("stall_release_addr", bus.imem_req_addr, 32'h80000008);

        // access fault at 0x80000008, then redirect clears it
        applyStimulus();
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b1);
        checkOutput("fault_set", 32'(bus.fault), 32'd1);
        checkOutput("fault_pc", bus.fault_pc, 32'h80000008);
        checkOutput("fault_req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("fault_inst_valid", 32'(bus.inst_valid), 32'd0);
        applyStimulus();
        checkOutput("fault_idle_req_valid", 32'(bus.imem_req_valid), 32'd0);
        checkOutput("fault_sticky", 32'(bus.fault), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80000000);
        checkOutput("fault_clear", 32'(bus.fault), 32'd0);
        checkOutput("fault_resume_valid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("fault_resume_addr", bus.imem_req_addr, 32'h80000000);

        // redirect while waiting, stale response two cycles later
        applyStimulus();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80000100);
        checkOutput("kill_req_valid", 32'(bus.imem_req_valid), 32'd0);
        applyStimulus();
        applyStimulus(1'b1, 1'b1, 32'hdeadbeef);
        checkOutput("kill_no_inst", 32'(bus.inst_valid), 32'd0);
        checkOutput("kill_req_valid2", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("kill_req_addr", bus.imem_req_addr, 32'h80000100);
        checkOutput("kill_no_fault", 32'(bus.fault), 32'd0);

        // redirect in HOLD with decode ready in the same cycle
        applyStimulus();
        applyStimulus(1'b1, 1'b1, 32'h00000013);
        checkOutput("hold2_inst_pc", bus.inst_pc, 32'h80000100);
        checkOutput("hold2_inst", bus.inst, 32'h00000013);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80000200);
        checkOutput("hold_redir_inst_valid", 32'(bus.inst_valid), 32'd0);
        checkOutput("hold_redir_addr", bus.imem_req_addr, 32'h80000200);

        // redirect coinciding with request fire
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80000300);
        checkOutput("fire_redir_wait", 32'(bus.imem_req_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'hcafef00d);
        checkOutput("fire_redir_no_inst", 32'(bus.inst_valid), 32'd0);
        checkOutput("fire_redir_addr", bus.imem_req_addr, 32'h80000300);

        // redirect in REQ while memory is not ready
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80000400);
        checkOutput("req_redir_valid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("req_redir_addr", bus.imem_req_addr, 32'h80000400);

        // pc wraps from the top of the address space
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hfffffffc);
        checkOutput("wrap_start_addr", bus.imem_req_addr, 32'hfffffffc);
        applyStimulus();
        applyStimulus(1'b1, 1'b1, 32'h00000013);
        checkOutput("wrap_inst_pc", bus.inst_pc, 32'hfffffffc);
        applyStimulus();
        checkOutput("wrap_addr", bus.imem_req_addr, 32'h00000000);

        // asynchronous reset in the middle of WAIT
        applyStimulus();
        checkOutput("prereset_wait", 32'(bus.imem_req_valid), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_inst", bus.inst, 32'h0);
        checkOutput("async_inst_pc", bus.inst_pc, 32'h0);
        checkOutput("async_fault_pc", bus.fault_pc, 32'h0);
        checkOutput("async_inst_valid", 32'(bus.inst_valid), 32'd0);
        checkOutput("async_req_valid", 32'(bus.imem_req_valid), 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h12345678;
        @(posedge clk);
        #1;
        bus.imem_rsp_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checkOutput("restart_req_valid", 32'(bus.imem_req_valid), 32'd1);
        checkOutput("restart_req_addr", bus.imem_req_addr, 32'h80000000);
        checkOutput("restart_inst_valid", 32'(bus.inst_valid), 32'd0);
        applyStimulus();
        applyStimulus(1'b1, 1'b1, 32'h00000413);
        checkOutput("restart_inst", bus.inst, 32'h00000413);
        checkOutput("restart_inst_pc", bus.inst_pc, 32'h80000000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
